// File: rtl/count_pkg.sv
// Shared encodings for the count_stream job engine.
package count_pkg;

  typedef enum logic [1:0] {
    SEL_RSVD  = 2'b00,
    SEL_ZERO  = 2'b01,
    SEL_ONE   = 2'b10,
    SEL_TRANS = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/popcnt_w.sv
// Combinational population count of a W-bit vector.
// Latency 0; no handshake.
module popcnt_w #(
  parameter  int W  = 8,
  localparam int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [PW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(vec[i]);
    end
  end

endmodule

// File: rtl/count_stream.sv
// Counts ones, zeros or adjacent-bit transitions over an nwords-long input stream.
// done pulses nwords+1 cycles after start plus one per stall; in_ready is high for the whole RUN state.
module count_stream
  import count_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int MAXN = 16,
  localparam int NW   = $clog2(MAXN) + 1,
  localparam int CW   = $clog2(W * MAXN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    sel,
  input  logic [NW-1:0] nwords,
  input  logic [W-1:0]  a_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] cntout
);

  localparam int PW = $clog2(W + 1);

  state_t        state, state_nxt;
  sel_t          mode;
  logic [NW-1:0] remaining;
  logic [CW-1:0] acc;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] contrib;
  logic          prev_bit;
  logic          first_word;
  logic          err_q;
  logic          cfg_ok;
  logic          accept;
  logic [W-1:0]  trans_vec;
  logic [PW-1:0] pc_data;
  logic [PW-1:0] pc_trans;

  assign cfg_ok = (sel != SEL_RSVD) && (nwords != '0) && (nwords <= NW'(MAXN));
  assign accept = in_valid && in_ready;

  // Bit 0 carries the word-boundary transition, suppressed for the first word of a job.
  assign trans_vec = {a_in[W-1:1] ^ a_in[W-2:0], first_word ? 1'b0 : (a_in[0] ^ prev_bit)};

  popcnt_w #(.W(W)) u_pc_data  (.vec(a_in),      .cnt(pc_data));
  popcnt_w #(.W(W)) u_pc_trans (.vec(trans_vec), .cnt(pc_trans));

  always_comb begin
    contrib = '0;
    case (mode)
      SEL_ONE:   contrib = CW'(pc_data);
      SEL_ZERO:  contrib = CW'(W) - CW'(pc_data);
      SEL_TRANS: contrib = CW'(pc_trans);
      default:   contrib = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_ok ? RUN : DONE;
      RUN:     if (accept && remaining == NW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= SEL_RSVD;
      remaining  <= '0;
      acc        <= '0;
      cnt_q      <= '0;
      prev_bit   <= 1'b0;
      first_word <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mode       <= sel_t'(sel);
            remaining  <= nwords;
            acc        <= '0;
            prev_bit   <= 1'b0;
            first_word <= 1'b1;
            err_q      <= !cfg_ok;
          end
        end
        RUN: begin
          if (accept) begin
            acc        <= acc + contrib;
            remaining  <= remaining - NW'(1);
            prev_bit   <= a_in[W-1];
            first_word <= 1'b0;
          end
        end
        DONE:    cnt_q <= acc;
        default: ;
      endcase
    end
  end

  // acc is cleared at launch, so an error job reports zero without a special case.
  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign err      = done && err_q;
  assign cntout   = done ? acc : cnt_q;

endmodule

// File: doc/count_stream.md
Name: count_stream

Overview:
- Parametrised multi-word successor to the single-word count_W8 bit counter.
- A job is launched by start. It then consumes nwords input words through a valid/ready handshake and reports one of three things over the whole stream: count of ones, count of zeros, or count of adjacent-bit transitions.
- Sits beside count_W8 in the datapath and uses the same start/done job semantics.

Parameters:
- W, 8, input word width in bits
- MAXN, 16, maximum number of words per job
- NW, $clog2(MAXN)+1, width of nwords (derived, not overridden)
- CW, $clog2(W*MAXN+1), width of cntout (derived; 8 at defaults)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  job launch; sampled only in IDLE
- sel  input  2  mode, sampled with start: 01 count zeros, 10 count ones, 11 count transitions, 00 reserved
- nwords  input  NW  words in the job, sampled with start; legal range 1..MAXN
- a_in  input  W  data word
- in_valid  input  1  a_in is valid
- in_ready  output  1  block accepts a_in this cycle
- busy  output  1  job in progress (RUN state)
- done  output  1  one-cycle pulse when the result is ready
- err  output  1  illegal configuration flag, valid when done=1
- cntout  output  CW  result of the last job; held until the next done

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state goes to IDLE.
  - in_ready, busy, done, err and cntout are all 0.
  - The accumulator and the saved previous bit are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch sel and nwords.
  - If the configuration is legal, go to RUN and set remaining=nwords.
  - If the configuration is illegal (sel=00, nwords=0 or nwords>MAXN), go to DONE with the error flag set.
  - start=0: stay in IDLE.
- RUN:
  - in_ready=1 and busy=1.
  - A word is accepted on any cycle where in_valid && in_ready.
  - Each accepted word updates the accumulator by its per-word contribution (mode rules below) and decrements remaining.
  - When the last word is accepted, go to DONE on the next edge.
  - in_valid=0 stalls the job: the accumulator holds and a_in is ignored. Stalls may be of any length.
- DONE:
  - Lasts exactly one cycle.
  - done=1; cntout = accumulator (0 on error); err = error flag.
  - Then return to IDLE.
- start is ignored in RUN and DONE; no queuing.
- Latency: with in_valid held high, done is asserted nwords+1 cycles after the start edge. Each stall cycle adds one.
- Mode rules:
  - ones: add popcount(a_in).
  - zeros: add W - popcount(a_in).
  - transitions:
    - Bits are taken LSB-first, word after word.
    - Add the popcount of a_in[i] ^ a_in[i-1] for i=1..W-1.
    - For every word except the first, also add a_in[0] ^ prev_bit, where prev_bit is the previous word's a_in[W-1].
    - The first word has no predecessor bit.
    - Maximum result is W*nwords-1.
- Width: CW covers W*MAXN, so the counter never overflows or saturates.
- cntout changes only in DONE (or on reset); it is stable while IDLE and RUN.
- Reset in the middle of RUN abandons the job; the next start behaves exactly as after power-up.
- start and rst high together: rst wins.

Decomposition:
- Package count_pkg holds:
  - sel encodings as an enum: SEL_RSVD=00, SEL_ZERO=01, SEL_ONE=10, SEL_TRANS=11.
  - The state enum: IDLE, RUN, DONE.
- Sub-module popcnt_w, parametrised by W: combinational popcount of a W-bit vector, output width $clog2(W+1).
  - Used twice: once on a_in, once on the transition vector.

Test Plan:
- sel=10, nwords=1, a_in=8'b0000_1011 with in_valid=1 -> done pulses 2 cycles after start; cntout=3; err=0.
- sel=01, nwords=3, words 8'h42, 8'hFF, 8'h00 sent back-to-back -> cntout=14 (6+0+8); done at cycle start+4.
- sel=11, nwords=2, words 8'h01, 8'h01 -> cntout=3, made up of in-word 1->0, the boundary 0->1 and in-word 1->0. Also nwords=16, sel=10, all words 8'hFF -> cntout=128.
- sel=10, nwords=2, words 8'h0F then 8'hF0, with 3 idle cycles between them during which a_in=8'hFF and in_valid=0 -> cntout=8; done is delayed by 3 cycles; start pulses during RUN are ignored.
- start with nwords=0, and separately with sel=00 -> done the cycle after start, err=1, cntout=0, no input words consumed.
- rst=1 for one cycle after 1 word of a 4-word job -> IDLE, cntout=0, done=0. A following job (sel=10, nwords=1, 8'hFF) gives cntout=8.
